// File: rtl/siso_shift_controller_if.sv
// Handshake and serial-loop signals between a SISO shift controller and its driver.
// The slave modport is the controller; the master drives requests and the chain return.
interface siso_shift_controller_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] din;
    logic             dir;
    logic             q_in;
    logic             so;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rx;
    logic             match;

    modport master (
        output start, din, dir, q_in,
        input  so, busy, done, rx, match
    );

    modport slave (
        input  start, din, dir, q_in,
        output so, busy, done, rx, match
    );
endinterface

// File: rtl/siso_shift_controller.sv
// Drives a word serially into an external DEPTH-stage SISO chain and reassembles
// the returning bits, flagging whether the loop-back word matches what was sent.
module siso_shift_controller #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    siso_shift_controller_if.slave bus
);
    localparam int CW = $clog2(WIDTH + DEPTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, FIN} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    t, t_n;
    logic [WIDTH-1:0] data, data_n;
    logic [WIDTH-1:0] rx, rx_n;
    logic             dir_q, dir_n;
    logic             so, so_n;
    logic             busy, busy_n;
    logic             done, done_n;
    logic             match, match_n;
    int               ti;
    int               tn;
    int               sel;
    int               cap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t     <= '0;
            data  <= '0;
            dir_q <= 1'b0;
            rx    <= '0;
            so    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            match <= 1'b0;
        end else begin
            t     <= t_n;
            data  <= data_n;
            dir_q <= dir_n;
            rx    <= rx_n;
            so    <= so_n;
            busy  <= busy_n;
            done  <= done_n;
            match <= match_n;
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_n = state;
        t_n     = t;
        data_n  = data;
        dir_n   = dir_q;
        rx_n    = rx;
        so_n    = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        match_n = match;
        ti      = int'(t);
        tn      = ti + 1;
        sel     = dir_q ? (WIDTH - 1 - tn) : tn;
        cap     = -1;

        // Bit k returns DEPTH cycles after it was sent; this may overlap SHIFT.
        if ((state == SHIFT || state == DRAIN) && ti >= DEPTH && ti < DEPTH + WIDTH)
            cap = dir_q ? (WIDTH - 1 - (ti - DEPTH)) : (ti - DEPTH);
        for (int i = 0; i < WIDTH; i++)
            if (i == cap) rx_n[i] = bus.q_in;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = SHIFT;
                    t_n     = '0;
                    data_n  = bus.din;
                    dir_n   = bus.dir;
                    rx_n    = '0;
                    match_n = 1'b0;
                    busy_n  = 1'b1;
                    so_n    = bus.dir ? bus.din[WIDTH-1] : bus.din[0];
                end
            end
            SHIFT: begin
                t_n    = t + CW'(1);
                busy_n = 1'b1;
                if (ti == WIDTH - 1) begin
                    state_n = DRAIN;
                end else begin
                    for (int i = 0; i < WIDTH; i++)
                        if (i == sel) so_n = data[i];
                end
            end
            DRAIN: begin
                t_n = t + CW'(1);
                if (ti == WIDTH + DEPTH - 1) begin
                    state_n = FIN;
                    done_n  = 1'b1;
                    match_n = (rx_n == data);
                end else begin
                    busy_n = 1'b1;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.so    = so;
    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.rx    = rx;
    assign bus.match = match;
endmodule

// File: tb/tb_siso_shift_controller.sv
// Directed bench: two controllers, each closed through an ideal SISO chain of
// matching depth (4 stages and 1 stage), checked against hand-computed results.
`timescale 1ns/1ps
module tb_siso_shift_controller;
    logic       clk;
    logic       rst_n;
    logic       force_zero;
    logic [3:0] chain_a;
    logic       chain_b;
    int         total;
    int         bad;

    siso_shift_controller_if #(.WIDTH(4)) ifa ();
    siso_shift_controller_if #(.WIDTH(4)) ifb ();

    siso_shift_controller #(.WIDTH(4), .DEPTH(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    siso_shift_controller #(.WIDTH(4), .DEPTH(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal SISO chains closing each loop.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_a <= '0;
            chain_b <= 1'b0;
        end else begin
            chain_a <= {chain_a[2:0], ifa.so};
            chain_b <= ifb.so;
        end
    end

    assign ifa.q_in = force_zero ? 1'b0 : chain_a[3];
    assign ifb.q_in = chain_b;

    task automatic run_transfer(input bit sel, input logic [3:0] d, input logic dr,
                                output logic [3:0] so_seq, output int busy_cnt,
                                output int done_at, output int done_cnt);
        logic s, b, dn;
        so_seq   = '0;
        busy_cnt = 0;
        done_at  = -1;
        done_cnt = 0;
        @(negedge clk);
        if (sel) begin
            ifb.din = d; ifb.dir = dr; ifb.start = 1'b1;
        end else begin
            ifa.din = d; ifa.dir = dr; ifa.start = 1'b1;
        end
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            ifa.start = 1'b0;
            ifb.start = 1'b0;
            s  = sel ? ifb.so   : ifa.so;
            b  = sel ? ifb.busy : ifa.busy;
            dn = sel ? ifb.done : ifa.done;
            if (cyc <= 4) so_seq[cyc-1] = s;
            if (b) busy_cnt++;
            if (dn) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (ifa.so !== 1'b0)    begin bad++; $display("[TB] FAIL reset_so: got %b want 0", ifa.so); end
        total++; if (ifa.busy !== 1'b0)  begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", ifa.busy); end
        total++; if (ifa.done !== 1'b0)  begin bad++; $display("[TB] FAIL reset_done: got %b want 0", ifa.done); end
        total++; if (ifa.rx !== 4'b0000) begin bad++; $display("[TB] FAIL reset_rx: got %b want 0000", ifa.rx); end
        total++; if (ifa.match !== 1'b0) begin bad++; $display("[TB] FAIL reset_match: got %b want 0", ifa.match); end
        total++; if (ifb.busy !== 1'b0)  begin bad++; $display("[TB] FAIL reset_busy_b: got %b want 0", ifb.busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lsb_first();
        logic [3:0] seq; int bc, da, dc;
        run_transfer(1'b0, 4'b1000, 1'b0, seq, bc, da, dc);
        total++; if (seq !== 4'b1000)    begin bad++; $display("[TB] FAIL lsb_so_seq: got %b want 1000", seq); end
        total++; if (da !== 9)           begin bad++; $display("[TB] FAIL lsb_done_at: got %0d want 9", da); end
        total++; if (dc !== 1)           begin bad++; $display("[TB] FAIL lsb_done_cnt: got %0d want 1", dc); end
        total++; if (ifa.rx !== 4'b1000) begin bad++; $display("[TB] FAIL lsb_rx: got %b want 1000", ifa.rx); end
        total++; if (ifa.match !== 1'b1) begin bad++; $display("[TB] FAIL lsb_match: got %b want 1", ifa.match); end
    endtask

    task automatic test_msb_first();
        logic [3:0] seq; int bc, da, dc;
        run_transfer(1'b0, 4'b1011, 1'b1, seq, bc, da, dc);
        total++; if (seq !== 4'b1101)    begin bad++; $display("[TB] FAIL msb_so_seq: got %b want 1101", seq); end
        total++; if (bc !== 8)           begin bad++; $display("[TB] FAIL msb_busy_cycles: got %0d want 8", bc); end
        total++; if (ifa.rx !== 4'b1011) begin bad++; $display("[TB] FAIL msb_rx: got %b want 1011", ifa.rx); end
        total++; if (ifa.match !== 1'b1) begin bad++; $display("[TB] FAIL msb_match: got %b want 1", ifa.match); end
    endtask

    task automatic test_q_forced_zero();
        logic [3:0] seq; int bc, da, dc;
        force_zero = 1'b1;
        run_transfer(1'b0, 4'b0110, 1'b0, seq, bc, da, dc);
        force_zero = 1'b0;
        total++; if (ifa.rx !== 4'b0000) begin bad++; $display("[TB] FAIL qzero_rx: got %b want 0000", ifa.rx); end
        total++; if (ifa.match !== 1'b0) begin bad++; $display("[TB] FAIL qzero_match: got %b want 0", ifa.match); end
        total++; if (dc !== 1)           begin bad++; $display("[TB] FAIL qzero_done_cnt: got %0d want 1", dc); end
    endtask

    task automatic test_start_held();
        int rise [8];
        logic [3:0] seq [8];
        int nr, r;
        logic prev;
        nr = 0;
        prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rise[i] = 0;
            seq[i]  = '0;
        end
        @(negedge clk);
        ifa.din = 4'b0011; ifa.dir = 1'b0; ifa.start = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (ifa.busy && !prev && nr < 8) begin
                rise[nr] = cyc;
                nr++;
            end
            if (nr > 0 && ifa.busy) begin
                r = cyc - rise[nr-1];
                if (r < 4) seq[nr-1][r] = ifa.so;
            end
            if (nr == 1 && cyc == rise[0] + 1) ifa.din = 4'b1100;
            prev = ifa.busy;
            @(negedge clk);
        end
        ifa.start = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (nr !== 4)                begin bad++; $display("[TB] FAIL held_starts: got %0d want 4", nr); end
        total++; if (rise[1] - rise[0] !== 10) begin bad++; $display("[TB] FAIL held_period1: got %0d want 10", rise[1] - rise[0]); end
        total++; if (rise[2] - rise[1] !== 10) begin bad++; $display("[TB] FAIL held_period2: got %0d want 10", rise[2] - rise[1]); end
        total++; if (seq[0] !== 4'b0011)      begin bad++; $display("[TB] FAIL held_so_first: got %b want 0011", seq[0]); end
        total++; if (seq[1] !== 4'b1100)      begin bad++; $display("[TB] FAIL held_so_second: got %b want 1100", seq[1]); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] seq; int bc, da, dc, dcnt;
        @(negedge clk);
        ifa.din = 4'b0100; ifa.dir = 1'b0; ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (ifa.busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_busy_before: got %b want 1", ifa.busy); end
        total++; if (ifa.so !== 1'b1)   begin bad++; $display("[TB] FAIL mid_so_before: got %b want 1", ifa.so); end
        rst_n = 1'b0;
        #1;
        total++; if (ifa.so !== 1'b0)    begin bad++; $display("[TB] FAIL mid_so_async: got %b want 0", ifa.so); end
        total++; if (ifa.busy !== 1'b0)  begin bad++; $display("[TB] FAIL mid_busy_async: got %b want 0", ifa.busy); end
        total++; if (ifa.rx !== 4'b0000) begin bad++; $display("[TB] FAIL mid_rx_async: got %b want 0000", ifa.rx); end
        total++; if (ifa.match !== 1'b0) begin bad++; $display("[TB] FAIL mid_match_async: got %b want 0", ifa.match); end
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (ifa.done) dcnt++;
        end
        total++; if (dcnt !== 0) begin bad++; $display("[TB] FAIL mid_no_done: got %0d want 0", dcnt); end
        run_transfer(1'b0, 4'b0100, 1'b1, seq, bc, da, dc);
        total++; if (seq !== 4'b0010)    begin bad++; $display("[TB] FAIL after_so_seq: got %b want 0010", seq); end
        total++; if (ifa.rx !== 4'b0100) begin bad++; $display("[TB] FAIL after_rx: got %b want 0100", ifa.rx); end
        total++; if (ifa.match !== 1'b1) begin bad++; $display("[TB] FAIL after_match: got %b want 1", ifa.match); end
        total++; if (dc !== 1)           begin bad++; $display("[TB] FAIL after_done_cnt: got %0d want 1", dc); end
    endtask

    task automatic test_overlap();
        logic [3:0] seq; int bc, da, dc;
        run_transfer(1'b1, 4'b0101, 1'b0, seq, bc, da, dc);
        total++; if (seq !== 4'b0101)    begin bad++; $display("[TB] FAIL ovl_so_seq: got %b want 0101", seq); end
        total++; if (da !== 6)           begin bad++; $display("[TB] FAIL ovl_done_at: got %0d want 6", da); end
        total++; if (dc !== 1)           begin bad++; $display("[TB] FAIL ovl_done_cnt: got %0d want 1", dc); end
        total++; if (bc !== 5)           begin bad++; $display("[TB] FAIL ovl_busy_cycles: got %0d want 5", bc); end
        total++; if (ifb.rx !== 4'b0101) begin bad++; $display("[TB] FAIL ovl_rx: got %b want 0101", ifb.rx); end
        total++; if (ifb.match !== 1'b1) begin bad++; $display("[TB] FAIL ovl_match: got %b want 1", ifb.match); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        force_zero = 1'b0;
        rst_n      = 1'b0;
        ifa.start  = 1'b0; ifa.din = '0; ifa.dir = 1'b0;
        ifb.start  = 1'b0; ifb.din = '0; ifb.dir = 1'b0;
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_q_forced_zero();
        test_start_held();
        test_reset_mid();
        test_overlap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end
endmodule
